prco_lmem_arbiter: RTL and testbench

- Arbitrates the single-port on-chip local memory between three requesters: instruction fetch (F), ALU load/store (L) and the debug/loader port (D).
- Sequences every access through a fixed 4-state FSM, matched to the memory's 1-cycle registered read.
- Presents a req/ack handshake to each requester and enforces a fetch anti-starvation rule.

---
 rtl/prco_lmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_prco_lmem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prco_lmem_arbiter.sv
// Local-memory arbiter: fetch, load/store and debug share one single-port RAM via a 4-state FSM.
// Each access takes 4 cycles (IDLE/ISSUE/CAPT/RESP); requesters hold their bundle until ack.
module prco_lmem_arbiter #(
  parameter int P_LMEM_DEPTH = 255,
  parameter int P_STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_f_req,
  input  logic [15:0] i_f_addr,
  output logic        q_f_ack,
  output logic [15:0] q_f_data,
  input  logic        i_l_req,
  input  logic        i_l_we,
  input  logic [15:0] i_l_addr,
  input  logic [15:0] i_l_dina,
  output logic        q_l_ack,
  output logic [15:0] q_l_data,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [15:0] i_d_addr,
  input  logic [15:0] i_d_dina,
  output logic        q_d_ack,
  output logic [15:0] q_d_data,
  output logic        q_mem_ce,
  output logic        q_mem_we,
  output logic [15:0] q_mem_addr,
  output logic [15:0] q_mem_dina,
  input  logic [15:0] i_mem_douta,
  output logic [1:0]  q_grant,
  output logic        q_busy,
  output logic        q_fault
);

  localparam int              CW    = $clog2(P_STARVE_MAX + 1);
  localparam logic [15:0]     DEPTH = 16'(P_LMEM_DEPTH);
  localparam logic [CW-1:0]   SMAX  = CW'(P_STARVE_MAX);

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_F    = 2'd1;
  localparam logic [1:0] G_L    = 2'd2;
  localparam logic [1:0] G_D    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_RESP} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          lat_we;
  logic          lat_fault;

  logic [1:0]  win;
  logic        win_we;
  logic [15:0] win_addr;
  logic [15:0] win_dina;
  logic        win_fault;

  // A starved fetch overrides the normal D > L > F order.
  always_comb begin
    win      = G_NONE;
    win_we   = 1'b0;
    win_addr = 16'h0000;
    win_dina = 16'h0000;
    if (i_f_req && starve_cnt == SMAX) begin
      win      = G_F;
      win_addr = i_f_addr;
    end else if (i_d_req) begin
      win      = G_D;
      win_we   = i_d_we;
      win_addr = i_d_addr;
      win_dina = i_d_dina;
    end else if (i_l_req) begin
      win      = G_L;
      win_we   = i_l_we;
      win_addr = i_l_addr;
      win_dina = i_l_dina;
    end else if (i_f_req) begin
      win      = G_F;
      win_addr = i_f_addr;
    end
    win_fault = (win_addr > DEPTH);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      lat_we     <= 1'b0;
      lat_fault  <= 1'b0;
      q_grant    <= G_NONE;
      q_mem_ce   <= 1'b0;
      q_mem_we   <= 1'b0;
      q_mem_addr <= 16'h0000;
      q_mem_dina <= 16'h0000;
      q_f_ack    <= 1'b0;
      q_l_ack    <= 1'b0;
      q_d_ack    <= 1'b0;
      q_f_data   <= 16'h0000;
      q_l_data   <= 16'h0000;
      q_d_data   <= 16'h0000;
      q_fault    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!i_f_req || win == G_F) begin
            starve_cnt <= '0;
          end else if (win != G_NONE && starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
          if (win != G_NONE) begin
            q_grant    <= win;
            lat_we     <= win_we;
            lat_fault  <= win_fault;
            // An out-of-range access never touches the memory.
            q_mem_ce   <= !win_fault;
            q_mem_we   <= win_we && !win_fault;
            q_mem_addr <= win_fault ? 16'h0000 : win_addr;
            q_mem_dina <= (win_we && !win_fault) ? win_dina : 16'h0000;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          q_mem_ce   <= 1'b0;
          q_mem_we   <= 1'b0;
          q_mem_addr <= 16'h0000;
          q_mem_dina <= 16'h0000;
          state      <= S_CAPT;
        end
        S_CAPT: begin
          q_fault <= lat_fault;
          case (q_grant)
            G_F: begin
              q_f_ack  <= 1'b1;
              q_f_data <= lat_fault ? 16'h0000 : i_mem_douta;
            end
            G_L: begin
              q_l_ack <= 1'b1;
              if (!lat_we) q_l_data <= lat_fault ? 16'h0000 : i_mem_douta;
            end
            G_D: begin
              q_d_ack <= 1'b1;
              if (!lat_we) q_d_data <= lat_fault ? 16'h0000 : i_mem_douta;
            end
            default: ;
          endcase
          state <= S_RESP;
        end
        S_RESP: begin
          q_f_ack <= 1'b0;
          q_l_ack <= 1'b0;
          q_d_ack <= 1'b0;
          q_fault <= 1'b0;
          q_grant <= G_NONE;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign q_busy = (state != S_IDLE);

endmodule

// File: tb/tb_prco_lmem_arbiter.sv
// Bench for prco_lmem_arbiter: directed scenarios then random request mixes,
// predicted by a transaction-level model (winner, starvation streak, shadow memory).
module tb_prco_lmem_arbiter;

  localparam int STARVE = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_f_req, i_l_req, i_l_we, i_d_req, i_d_we;
  logic [15:0] i_f_addr, i_l_addr, i_l_dina, i_d_addr, i_d_dina;
  logic        q_f_ack, q_l_ack, q_d_ack;
  logic [15:0] q_f_data, q_l_data, q_d_data;
  logic        q_mem_ce, q_mem_we;
  logic [15:0] q_mem_addr, q_mem_dina;
  logic [15:0] i_mem_douta;
  logic [1:0]  q_grant;
  logic        q_busy, q_fault;

  prco_lmem_arbiter #(.P_LMEM_DEPTH(255), .P_STARVE_MAX(STARVE)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_f_req(i_f_req), .i_f_addr(i_f_addr), .q_f_ack(q_f_ack), .q_f_data(q_f_data),
    .i_l_req(i_l_req), .i_l_we(i_l_we), .i_l_addr(i_l_addr), .i_l_dina(i_l_dina),
    .q_l_ack(q_l_ack), .q_l_data(q_l_data),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_dina(i_d_dina),
    .q_d_ack(q_d_ack), .q_d_data(q_d_data),
    .q_mem_ce(q_mem_ce), .q_mem_we(q_mem_we), .q_mem_addr(q_mem_addr),
    .q_mem_dina(q_mem_dina), .i_mem_douta(i_mem_douta),
    .q_grant(q_grant), .q_busy(q_busy), .q_fault(q_fault)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] init_val(input int a);
    if (a == 8'haa) return 16'h00CA;
    return 16'(a * 37 + 16'h1234);
  endfunction

  // Single-port RAM with 1-cycle registered read.
  logic        mem_load;
  logic [15:0] tb_mem [256];
  always @(posedge i_clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
    end else if (q_mem_ce) begin
      if (q_mem_we) tb_mem[q_mem_addr[7:0]] <= q_mem_dina;
      else          i_mem_douta <= tb_mem[q_mem_addr[7:0]];
    end
  end

  // Requester bundles indexed 0=F, 1=L, 2=D; model state.
  logic        req [3];
  logic        we  [3];
  logic [15:0] addr [3];
  logic [15:0] dina [3];
  logic [15:0] ref_mem [256];
  logic [15:0] exp_data [3];
  int          streak;
  logic        hold_all;
  int          last_grant;
  int          pass_no;
  int          n_err;
  int          n_checks;
  int          seq [10];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (pass %0d): observed=%h expected=%h", tag, pass_no, obs, exp);
    end
  endtask

  task automatic drive();
    i_f_req  = req[0]; i_f_addr = addr[0];
    i_l_req  = req[1]; i_l_we   = we[1]; i_l_addr = addr[1]; i_l_dina = dina[1];
    i_d_req  = req[2]; i_d_we   = we[2]; i_d_addr = addr[2]; i_d_dina = dina[2];
  endtask

  task automatic set_req(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
    req[i] = 1'b1; we[i] = (i == 0) ? 1'b0 : w; addr[i] = a; dina[i] = d;
  endtask

  // One full arbitration pass; caller guarantees the DUT is idle and at least one req is up.
  task automatic run_pass();
    int         w;
    logic       flt, wr;
    logic [2:0] ackv;
    pass_no++;
    if (req[0] && streak == STARVE) w = 0;
    else if (req[2])                w = 2;
    else if (req[1])                w = 1;
    else                            w = 0;
    if (!req[0] || w == 0) streak = 0;
    else if (streak < STARVE) streak++;
    wr  = (w != 0) && we[w];
    flt = addr[w] > 16'd255;
    if (flt) begin
      if (!wr) exp_data[w] = 16'h0000;
    end else if (wr) begin
      ref_mem[addr[w][7:0]] = dina[w];
    end else begin
      exp_data[w] = ref_mem[addr[w][7:0]];
    end

    @(posedge i_clk); #1;
    last_grant = int'(q_grant);
    chk("issue_grant", 16'(q_grant), 16'(w + 1));
    chk("issue_busy", 16'(q_busy), 16'd1);
    chk("issue_ce", 16'(q_mem_ce), 16'(!flt));
    if (!flt) begin
      chk("issue_addr", q_mem_addr, addr[w]);
      chk("issue_we", 16'(q_mem_we), 16'(wr));
      if (wr) chk("issue_dina", q_mem_dina, dina[w]);
    end

    @(posedge i_clk); #1;
    chk("capt_ce", 16'(q_mem_ce), 16'd0);
    chk("capt_ack", 16'({q_d_ack, q_l_ack, q_f_ack}), 16'd0);

    @(posedge i_clk); #1;
    ackv = 3'b001 << w;
    chk("resp_ack", 16'({q_d_ack, q_l_ack, q_f_ack}), 16'(ackv));
    chk("resp_fault", 16'(q_fault), 16'(flt));
    chk("resp_ce", 16'(q_mem_ce), 16'd0);
    chk("f_data", q_f_data, exp_data[0]);
    chk("l_data", q_l_data, exp_data[1]);
    chk("d_data", q_d_data, exp_data[2]);
    if (!hold_all) begin
      req[w] = 1'b0;
      drive();
    end

    @(posedge i_clk); #1;
    chk("idle_grant", 16'(q_grant), 16'd0);
    chk("idle_ack", 16'({q_d_ack, q_l_ack, q_f_ack, q_fault, q_busy}), 16'd0);
  endtask

  task automatic rand_reqs();
    int any;
    for (int i = 0; i < 3; i++) begin
      if (!req[i] && $urandom_range(0, 1) == 1) begin
        set_req(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535))
                                            : 16'($urandom_range(0, 31)),
                16'($urandom));
      end
    end
    any = 0;
    for (int i = 0; i < 3; i++) if (req[i]) any = 1;
    if (any == 0) set_req(int'($urandom_range(0, 2)), 1'b0, 16'($urandom_range(0, 31)), 16'h0);
    drive();
  endtask

  initial begin
    n_err = 0; n_checks = 0; pass_no = 0; streak = 0; hold_all = 1'b0; last_grant = 0;
    seq = '{3, 3, 3, 3, 1, 3, 3, 3, 3, 1};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 16'h0; dina[i] = 16'h0; exp_data[i] = 16'h0;
    end
    drive();
    i_reset  = 1'b0;
    mem_load = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 mem_load = 1'b0;
    chk("rst_ctl", 16'({q_grant, q_busy, q_mem_ce, q_mem_we, q_f_ack, q_l_ack, q_d_ack, q_fault}), 16'd0);
    chk("rst_data", q_f_data | q_l_data | q_d_data | q_mem_addr | q_mem_dina, 16'd0);
    #3 i_reset = 1'b1;
    @(posedge i_clk); #1;

    // Single fetch read.
    set_req(0, 1'b0, 16'h00aa, 16'h0); drive();
    run_pass();
    chk("f_read_ca", q_f_data, 16'h00CA);

    // Store then load through L.
    set_req(1, 1'b1, 16'h0010, 16'hBEEF); drive();
    run_pass();
    set_req(1, 1'b0, 16'h0010, 16'h0); drive();
    run_pass();
    chk("l_load_beef", q_l_data, 16'hBEEF);

    // Three simultaneous requests: D, L, then F.
    set_req(0, 1'b0, 16'h00aa, 16'h0);
    set_req(1, 1'b0, 16'h0010, 16'h0);
    set_req(2, 1'b0, 16'h0020, 16'h0);
    drive();
    for (int k = 0; k < 3; k++) begin
      run_pass();
      chk("order_dlf", 16'(last_grant), 16'(3 - k));
    end

    // Starvation: D and L held, F held; F every fifth grant.
    hold_all = 1'b1;
    set_req(0, 1'b0, 16'h0003, 16'h0);
    set_req(1, 1'b0, 16'h0004, 16'h0);
    set_req(2, 1'b0, 16'h0005, 16'h0);
    drive();
    for (int k = 0; k < 10; k++) begin
      run_pass();
      chk("starve_seq", 16'(last_grant), 16'(seq[k]));
    end
    hold_all = 1'b0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    drive();
    @(posedge i_clk); #1;

    // Out-of-range debug read.
    set_req(2, 1'b0, 16'h0100, 16'h0); drive();
    run_pass();
    chk("fault_d_data", q_d_data, 16'h0000);

    // Asynchronous reset in the middle of an L read.
    set_req(1, 1'b0, 16'h0010, 16'h0); drive();
    @(posedge i_clk); #1;
    @(posedge i_clk); #3;
    i_reset = 1'b0;
    #1;
    chk("arst_ctl", 16'({q_grant, q_busy, q_mem_ce, q_mem_we, q_f_ack, q_l_ack, q_d_ack, q_fault}), 16'd0);
    chk("arst_data", q_f_data | q_l_data | q_d_data | q_mem_addr | q_mem_dina, 16'd0);
    for (int i = 0; i < 3; i++) exp_data[i] = 16'h0;
    streak = 0;
    @(posedge i_clk); #1;
    chk("arst_no_ack", 16'({q_l_ack, q_busy}), 16'd0);
    req[1] = 1'b0; drive();
    #3 i_reset = 1'b1;
    @(posedge i_clk); #1;
    set_req(1, 1'b0, 16'h0010, 16'h0); drive();
    run_pass();
    chk("arst_recover", q_l_data, 16'hBEEF);

    // Random request mixes.
    for (int k = 0; k < 60; k++) begin
      rand_reqs();
      run_pass();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
